// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA timing generator: 800x600 @ 60 Hz defaults,
// derived totals/sync windows, and the count width used on every axis.
package vga_timing_pkg;

  localparam int unsigned CountW = 11;
  // Totals are formed at 12 bits so a 2047-wide axis cannot overflow.
  localparam int unsigned TotalW = 12;

  typedef logic [TotalW-1:0] total_t;

  localparam int unsigned HActiveDef = 800;
  localparam int unsigned HFpDef     = 40;
  localparam int unsigned HSyncDef   = 128;
  localparam int unsigned HBpDef     = 88;

  localparam int unsigned VActiveDef = 600;
  localparam int unsigned VFpDef     = 1;
  localparam int unsigned VSyncDef   = 4;
  localparam int unsigned VBpDef     = 23;

  localparam int unsigned HTotalDef     = HActiveDef + HFpDef + HSyncDef + HBpDef;
  localparam int unsigned HSyncStartDef = HActiveDef + HFpDef;
  localparam int unsigned HSyncEndDef   = HActiveDef + HFpDef + HSyncDef;

  localparam int unsigned VTotalDef     = VActiveDef + VFpDef + VSyncDef + VBpDef;
  localparam int unsigned VSyncStartDef = VActiveDef + VFpDef;
  localparam int unsigned VSyncEndDef   = VActiveDef + VFpDef + VSyncDef;

  function automatic total_t axis_total(input int unsigned active, input int unsigned fp,
                                        input int unsigned sync, input int unsigned bp);
    return total_t'(active + fp + sync + bp);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping counter with registered blank and sync flags
// derived from the next-state count, so flags and count stay co-registered.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = HActiveDef,
  parameter int unsigned FP     = HFpDef,
  parameter int unsigned SYNC   = HSyncDef,
  parameter int unsigned BP     = HBpDef,
  parameter logic        POL    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adv,
  output logic [CountW-1:0] count,
  output logic              blnk,
  output logic              sync,
  output logic              wrap
);

  localparam total_t Total     = axis_total(ACTIVE, FP, SYNC, BP);
  localparam total_t Last      = Total - total_t'(1);
  localparam total_t Active    = total_t'(ACTIVE);
  localparam total_t SyncStart = total_t'(ACTIVE + FP);
  localparam total_t SyncEnd   = total_t'(ACTIVE + FP + SYNC);

  logic [CountW-1:0] count_q, count_d;
  logic              blnk_q, blnk_d;
  logic              sync_q, sync_d;
  logic              at_last;
  total_t            count_ext_d;

  // Next count and the flags that will describe it once registered.
  always_comb begin
    at_last     = ({1'b0, count_q} == Last);
    wrap        = adv & at_last;
    count_d     = count_q;
    if (adv) begin
      count_d = at_last ? '0 : count_q + CountW'(1);
    end
    count_ext_d = {1'b0, count_d};
    blnk_d      = (count_ext_d >= Active);
    sync_d      = ((count_ext_d >= SyncStart) && (count_ext_d < SyncEnd)) ? POL : ~POL;
  end

  // Axis state; reset puts the sync line at its inactive level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      blnk_q  <= 1'b0;
      sync_q  <= ~POL;
    end else begin
      count_q <= count_d;
      blnk_q  <= blnk_d;
      sync_q  <= sync_d;
    end
  end

  assign count = count_q;
  assign blnk  = blnk_q;
  assign sync  = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing source (default 800x600 @ 60 Hz, 40 MHz).
// Optional frame tick/counter ports exist only when VGA_TIMING_FRAME_CNT_EN
// is defined; counter and sync behaviour is identical either way.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = HActiveDef,
  parameter int unsigned H_FP      = HFpDef,
  parameter int unsigned H_SYNC    = HSyncDef,
  parameter int unsigned H_BP      = HBpDef,
  parameter int unsigned V_ACTIVE  = VActiveDef,
  parameter int unsigned V_FP      = VFpDef,
  parameter int unsigned V_SYNC    = VSyncDef,
  parameter int unsigned V_BP      = VBpDef,
  parameter logic        HSYNC_POL = 1'b1,
  parameter logic        VSYNC_POL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [CountW-1:0] hcount_out,
  output logic              hsync_out,
  output logic              hblnk_out,
  output logic [CountW-1:0] vcount_out,
  output logic              vsync_out,
  output logic              vblnk_out
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic              frame_tick,
  output logic [15:0]       frame_cnt
`endif
);

  logic h_wrap;
  logic v_wrap;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HSYNC_POL)
  ) u_h_axis (
    .clk   (clk),
    .rst   (rst),
    .adv   (1'b1),
    .count (hcount_out),
    .blnk  (hblnk_out),
    .sync  (hsync_out),
    .wrap  (h_wrap)
  );

  // Vertical axis steps only on the cycle the horizontal axis wraps.
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VSYNC_POL)
  ) u_v_axis (
    .clk   (clk),
    .rst   (rst),
    .adv   (h_wrap),
    .count (vcount_out),
    .blnk  (vblnk_out),
    .sync  (vsync_out),
    .wrap  (v_wrap)
  );

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic        frame_tick_q;
  logic [15:0] frame_cnt_q;

  // v_wrap means the next state is (0,0), so the registered tick lines up
  // with the outputs showing (0,0); the post-reset (0,0) never sees it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_tick_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      frame_tick_q <= v_wrap;
      if (v_wrap) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  assign frame_tick = frame_tick_q;
  assign frame_cnt  = frame_cnt_q;
`else
  logic unused_v_wrap;
  assign unused_v_wrap = v_wrap;
`endif

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Source end of the video timing stream consumed by every drawing stage in the game pipeline. Generates `hcount`, `vcount`, sync and blanking signals for a fixed-mode VGA raster, defaulting to 800x600 @ 60 Hz on a 40 MHz pixel clock. Sits at the head of the chain and feeds the background stage, then `draw_rect` and the other overlay stages. All outputs are registered and mutually aligned.

## Interface
- `H_ACTIVE`, 800: visible pixels per line.
- `H_FP`, 40: horizontal front porch, in pixels.
- `H_SYNC`, 128: hsync pulse width, in pixels.
- `H_BP`, 88: horizontal back porch. H_TOTAL = 1056.
- `V_ACTIVE`, 600: visible lines.
- `V_FP`, 1: vertical front porch, in lines.
- `V_SYNC`, 4: vsync pulse width, in lines.
- `V_BP`, 23: vertical back porch. V_TOTAL = 628.
- `HSYNC_POL`, 1: active level of `hsync_out`.
- `VSYNC_POL`, 1: active level of `vsync_out`.
- `clk`  in  1  pixel clock.
- `rst`  in  1  asynchronous, active-high reset.
- `hcount_out`  out  11  pixel index within line, 0..H_TOTAL-1.
- `hsync_out`  out  1  horizontal sync, polarity per HSYNC_POL.
- `hblnk_out`  out  1  high when hcount_out >= H_ACTIVE.
- `vcount_out`  out  11  line index, 0..V_TOTAL-1.
- `vsync_out`  out  1  vertical sync, polarity per VSYNC_POL.
- `vblnk_out`  out  1  high when vcount_out >= V_ACTIVE.
- `frame_tick`  out  1  present only under macro; one-cycle pulse on wrap to (0,0).
- `frame_cnt`  out  16  present only under macro; completed-frame count.

## Operation
- Horizontal counter increments every clk.
- At H_TOTAL-1, the horizontal counter wraps to 0 and the vertical counter advances.
- At (H_TOTAL-1, V_TOTAL-1), both counters wrap to 0.
- hsync is active for H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, i.e. 840..967.
- vsync is active for V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC, i.e. 601..604.
- vsync and vblnk change only at line boundaries, in the same cycle that hcount_out becomes 0.
- Blank and sync flags are computed from the next-state counter values and registered. Every output in a given cycle therefore describes the same pixel; there is no skew between counts and flags.
- Reset values:
  - hcount_out = 0, vcount_out = 0.
  - hblnk_out = 0, vblnk_out = 0.
  - hsync_out = ~HSYNC_POL, vsync_out = ~VSYNC_POL.
  - frame_tick = 0, frame_cnt = 0.
- Reset asserted mid-frame returns all outputs to their reset values immediately, with no wait for the clock. Counting resumes on the first clk edge after deassertion.
- Width rule: H_TOTAL and V_TOTAL must be <= 2048. Totals are computed with 12-bit intermediates, so there is no overflow at 2047.

## Timing
- No input-to-output latency: the block is free-running. The first edge after reset release yields hcount_out = 1.
- Line period: H_TOTAL clocks. Frame period: H_TOTAL*V_TOTAL clocks, 663 168 at the defaults.
- hblnk_out rises on the edge where hcount_out becomes H_ACTIVE (800). It falls on the edge where hcount_out becomes 0.
- Downstream stages rely on count, flags and sync always being co-registered. Any pipeline delay added inside this block must be applied to all outputs equally.

## Configuration
- Macro: `VGA_TIMING_FRAME_CNT_EN`.
- With the macro defined:
  - `frame_tick` and `frame_cnt` ports exist.
  - `frame_tick` is high for exactly the one cycle in which the outputs show (0,0), except the first (0,0) after reset.
  - `frame_cnt` increments in that same cycle and wraps 0xFFFF -> 0.
- Without the macro: both ports and their logic are absent. Counter and sync behaviour is identical.

## Structure
- Package `vga_timing_pkg`:
  - 800x600 default constants.
  - Derived H_TOTAL/V_TOTAL and sync start/end constants.
  - Count width constant (11).
- Sub-module `vga_axis_counter`:
  - Parameterised by ACTIVE, FP, SYNC, BP and POL.
  - Input `adv`; outputs `count`, `blnk`, `sync` and `wrap`.
  - Instantiated twice:
    - horizontal, with adv tied to 1;
    - vertical, with adv driven by the horizontal `wrap`.

## Test plan
- Hold rst high, toggle clk -> all outputs at reset values. hsync_out = 0 and vsync_out = 0 with default polarity.
- Release reset, run 1056 clocks:
  - hcount_out sequences 1..1055, then 0;
  - vcount_out steps 0 -> 1 at the wrap;
  - hblnk_out is high for counts 800..1055;
  - hsync_out is high for counts 840..967.
- Run one full frame (663 168 clocks) -> vblnk_out high for lines 600..627, vsync_out high for lines 601..604, both counts return to (0,0).
- Assert rst asynchronously at hcount 500, vcount 300 -> outputs are zero before the next clk edge, and counting restarts from 1 after release.
- With `VGA_TIMING_FRAME_CNT_EN` defined, run three frames -> three single-cycle `frame_tick` pulses at (0,0) and `frame_cnt` reading 3. Preload to 0xFFFF via force -> the next frame reads 0.
- Set HSYNC_POL = 0 and VSYNC_POL = 0 -> sync outputs are inverted, idle high at reset, with unchanged windows.
